// File: rtl/hit_judge.sv
// Reaction-game judge: one round per lit-LED window. It scores correct presses,
// counts wrong presses and timeouts, and locks into game over after MAX_MISSES.

module hj_btn_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic bedge
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // The registered edge adds one stage, so press-to-judgement is SYNC_STAGES+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            prev  <= 1'b0;
            bedge <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn};
            prev  <= sync[SYNC_STAGES-1];
            bedge <= sync[SYNC_STAGES-1] & ~prev;
        end
    end
endmodule

module hit_judge #(
    parameter int SCORE_W     = 8,
    parameter int MAX_MISSES  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         LED,
    input  logic [29:0]        light_dur,
    input  logic [7:0]         btn,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic [29:0]        react,
    output logic               game_over
);
    typedef enum logic [1:0] {IDLE, ARMED, JUDGED, OVER} state_t;

    state_t      state, nstate;
    logic [7:0]  bedge;
    logic [7:0]  tgt;
    logic [29:0] dur;
    logic [29:0] cnt;
    logic [29:0] cnt_nxt;
    logic [30:0] cnt_inc;
    logic        is_hit, timeout;
    logic        hit_ev, miss_ev, start, last_miss;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_lane
            hj_btn_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn[i]),
                .bedge(bedge[i])
            );
        end
    endgenerate

    assign cnt_inc = {1'b0, cnt} + 31'd1;
    assign cnt_nxt = (&cnt) ? cnt : cnt_inc[29:0];
    assign is_hit  = (|(bedge & tgt)) && !(|(bedge & ~tgt));
    assign timeout = (dur != '0) && (cnt_inc >= {1'b0, dur});

    always_comb begin
        hit_ev  = 1'b0;
        miss_ev = 1'b0;
        start   = 1'b0;
        nstate  = state;
        case (state)
            IDLE: begin
                start = (LED != 8'h00);
                if (start) nstate = ARMED;
            end
            ARMED: begin
                // A changed or dark LED outranks a same-cycle press.
                if (LED != tgt) begin
                    miss_ev = 1'b1;
                    start   = (LED != 8'h00);
                    nstate  = start ? ARMED : IDLE;
                end else if (bedge != 8'h00) begin
                    hit_ev  = is_hit;
                    miss_ev = !is_hit;
                    nstate  = JUDGED;
                end else if (timeout) begin
                    miss_ev = 1'b1;
                    nstate  = JUDGED;
                end
            end
            JUDGED: begin
                if (LED == 8'h00) begin
                    nstate = IDLE;
                end else if (LED != tgt) begin
                    start  = 1'b1;
                    nstate = ARMED;
                end
            end
            default: nstate = OVER;
        endcase
        last_miss = miss_ev && (misses == 4'(MAX_MISSES - 1));
        if (last_miss) nstate = OVER;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tgt       <= '0;
            dur       <= '0;
            cnt       <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            score     <= '0;
            misses    <= '0;
            react     <= '0;
            game_over <= 1'b0;
        end else begin
            state <= nstate;
            hit   <= hit_ev;
            miss  <= miss_ev;
            if (start) begin
                tgt <= LED;
                dur <= light_dur;
                cnt <= '0;
            end else if (state == ARMED) begin
                cnt <= cnt_nxt;
            end
            if (hit_ev) begin
                react <= cnt_nxt;
                if (score != '1) score <= score + 1'b1;
            end
            if (miss_ev) misses <= misses + 4'd1;
            if (last_miss) game_over <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: reset, hit latency, wrong press, timeouts,
// game over and score saturation (second instance with SCORE_W=2).

module tb_hit_judge;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  LED;
    logic [29:0] light_dur;
    logic [7:0]  btn;

    logic        hit, miss, game_over;
    logic [7:0]  score;
    logic [3:0]  misses;
    logic [29:0] react;

    logic        hit2, miss2, game_over2;
    logic [1:0]  score2;
    logic [3:0]  misses2;
    logic [29:0] react2;

    int total = 0, bad = 0;
    int cyc = 0;
    int hit_n = 0, miss_n = 0, hit2_n = 0;
    int last_hit = -1, last_miss = -1;
    int t0, h0, m0;

    hit_judge #(.SCORE_W(8), .MAX_MISSES(3), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .LED(LED), .light_dur(light_dur), .btn(btn),
        .hit(hit), .miss(miss), .score(score), .misses(misses),
        .react(react), .game_over(game_over)
    );

    hit_judge #(.SCORE_W(2), .MAX_MISSES(15), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .LED(LED), .light_dur(light_dur), .btn(btn),
        .hit(hit2), .miss(miss2), .score(score2), .misses(misses2),
        .react(react2), .game_over(game_over2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (hit)  begin hit_n++;  last_hit  = cyc; end
        if (miss) begin miss_n++; last_miss = cyc; end
        if (hit2) hit2_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] led_v, input logic [7:0] b);
        LED = led_v; light_dur = 30'd0;
        step(2);
        btn = b;
        step(6);
        btn = 8'h00; LED = 8'h00;
        step(2);
    endtask

    initial begin
        rst = 1'b1; LED = 8'h00; light_dur = 30'd0; btn = 8'h00;
        #22 rst = 1'b0;
        step(1);
        chk("rst_hit", hit, 0);
        chk("rst_miss", miss, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_react", react, 0);
        chk("rst_over", game_over, 0);

        // Hit: press 10 clocks into the round, judged 3 clocks later
        LED = 8'h04; light_dur = 30'd100; t0 = cyc;
        step(10);
        btn = 8'h04;
        step(5);
        chk("hit_cnt", hit_n, 1);
        chk("hit_cyc", last_hit, t0 + 14);
        chk("hit_score", score, 1);
        chk("hit_react", react, 13);
        chk("hit_nomiss", miss_n, 0);
        LED = 8'h00;
        step(2);
        btn = 8'h00;
        step(2);

        // Wrong press, then a correct press in the same window is ignored
        LED = 8'h04; light_dur = 30'd0;
        step(3);
        btn = 8'h20;
        step(6);
        chk("wrong_miss", miss_n, 1);
        chk("wrong_misses", misses, 1);
        chk("wrong_score", score, 1);
        btn = 8'h00;
        step(2);
        btn = 8'h04;
        step(6);
        chk("late_nohit", hit_n, 1);
        chk("late_nomiss", miss_n, 1);
        btn = 8'h00; LED = 8'h00;
        step(2);

        // Asynchronous reset in the middle of an armed round
        LED = 8'h10;
        step(3);
        #3 rst = 1'b1;
        #1;
        chk("arst_score", score, 0);
        chk("arst_misses", misses, 0);
        chk("arst_react", react, 0);
        LED = 8'h00;
        #10 rst = 1'b0;
        h0 = hit_n; m0 = miss_n;
        step(20);
        chk("arst_nopulse", (hit_n - h0) + (miss_n - m0), 0);

        // Timeout lands exactly 50 clocks after round start
        LED = 8'h80; light_dur = 30'd50; t0 = cyc;
        step(60);
        chk("tmo_cnt", miss_n, m0 + 1);
        chk("tmo_cyc", last_miss, t0 + 51);
        chk("tmo_misses", misses, 1);
        LED = 8'h00;
        step(2);

        // LED dropping early gives exactly one miss
        LED = 8'h80; light_dur = 30'd50;
        step(20);
        LED = 8'h00;
        step(3);
        chk("drop_miss", miss_n, m0 + 2);
        step(50);
        chk("drop_once", miss_n, m0 + 2);
        chk("drop_over", game_over, 0);

        // Third miss ends the game; later hits are frozen out
        LED = 8'h01;
        step(2);
        btn = 8'h02;
        step(6);
        chk("go_misses", misses, 3);
        chk("go_flag", game_over, 1);
        btn = 8'h00; LED = 8'h00;
        step(2);
        h0 = hit_n;
        press(8'h01, 8'h01);
        press(8'h01, 8'h01);
        chk("go_score", score, 0);
        chk("go_nohit", hit_n, h0);
        chk("go_still", game_over, 1);

        // Saturation on the 2-bit instance, with multi-bit targets
        #3 rst = 1'b1;
        #10 rst = 1'b0;
        step(2);
        h0 = hit2_n;
        press(8'h08, 8'h08);
        press(8'h0C, 8'h04);
        press(8'h0C, 8'h0C);
        press(8'h0C, 8'h08);
        press(8'h01, 8'h01);
        chk("sat_hits", hit2_n - h0, 5);
        chk("sat_score2", score2, 3);
        chk("sat_score8", score, 5);

        // Held button across two rounds produces only one hit
        LED = 8'h08;
        step(2);
        btn = 8'h08;
        step(6);
        LED = 8'h00;
        step(2);
        LED = 8'h08;
        step(8);
        chk("held_score", score, 6);
        btn = 8'h00; LED = 8'h00;
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
